// File: rtl/fp64_pkg.sv
// Shared fp64 constants, FSM state type and operand classification helpers.
// Imported by the sequential multiplier and divider.
package fp64_pkg;

  localparam int unsigned SIGN_W = 1;
  localparam int unsigned EXP_W  = 11;
  localparam int unsigned FRAC_W = 52;
  localparam int unsigned BIAS   = 1023;

  localparam logic [63:0]      QNAN    = 64'h7FF8000000000000;
  localparam logic [EXP_W-1:0] EXP_INF = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM
  } state_t;

  function automatic logic fp_is_nan(input logic [63:0] x);
    return (x[62:52] == EXP_INF) && (x[FRAC_W-1:0] != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [63:0] x);
    return (x[62:52] == EXP_INF) && (x[FRAC_W-1:0] == '0);
  endfunction

  // Subnormals are flushed: any zero exponent field counts as zero.
  function automatic logic fp_is_zero(input logic [63:0] x);
    return x[62:52] == '0;
  endfunction

endpackage

// File: rtl/fp64_mul_seq_if.sv
// Start/done request bus shared by the sequential fp64 arithmetic units.
interface fp64_mul_seq_if;
  logic        i_start;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_z;
  logic        o_invalid;
  logic        o_overflow;
  logic        o_underflow;

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_z, o_invalid, o_overflow, o_underflow
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_z, o_invalid, o_overflow, o_underflow
  );
endinterface

// File: rtl/fp64_round_pack.sv
// Normalizes a 106-bit significand product, rounds to nearest-even and packs
// an fp64 result with overflow/underflow saturation.
module fp64_round_pack
  import fp64_pkg::*;
(
  input  logic               i_sign,
  input  logic signed [12:0] i_exp,
  input  logic [105:0]       i_prod,
  output logic [63:0]        o_z,
  output logic               o_overflow,
  output logic               o_underflow
);

  logic               w_hi;
  logic [51:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_round_up;
  logic [52:0]        w_mant_rnd;
  logic signed [12:0] w_exp_norm;
  logic signed [12:0] w_exp_fin;

  always_comb begin
    w_hi       = i_prod[105];
    w_mant     = w_hi ? i_prod[104:53] : i_prod[103:52];
    w_guard    = w_hi ? i_prod[52] : i_prod[51];
    w_sticky   = w_hi ? (|i_prod[51:0]) : (|i_prod[50:0]);
    w_exp_norm = i_exp + (w_hi ? 13'sd1 : 13'sd0);
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    // A carry out of the mantissa means it rolled over to 2.0: fraction is already 0.
    w_mant_rnd = {1'b0, w_mant} + {52'd0, w_round_up};
    w_exp_fin  = w_exp_norm + (w_mant_rnd[52] ? 13'sd1 : 13'sd0);

    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_exp_fin >= 13'sd2047) begin
      o_z        = {i_sign, EXP_INF, 52'd0};
      o_overflow = 1'b1;
    end else if (w_exp_fin <= 13'sd0) begin
      o_z         = {i_sign, 63'd0};
      o_underflow = 1'b1;
    end else begin
      o_z = {i_sign, w_exp_fin[10:0], w_mant_rnd[51:0]};
    end
  end

endmodule

// File: rtl/fp64_mul_seq.sv
// Sequential IEEE-754 double multiplier: iterative shift-add over the 53-bit
// significands, ITER_BITS multiplier bits per cycle, then round/pack.
module fp64_mul_seq
  import fp64_pkg::*;
#(
  parameter int unsigned ITER_BITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  fp64_mul_seq_if.slave bus
);

  localparam int unsigned ITERS = (53 + ITER_BITS - 1) / ITER_BITS;
  localparam int unsigned BW    = ITERS * ITER_BITS;
  localparam int unsigned KW    = $clog2(ITERS);
  localparam int unsigned PPW   = 53 + ITER_BITS;

  state_t r_state, w_next;

  logic [105:0]       r_p;
  logic [52:0]        r_a;
  logic [BW-1:0]      r_b;
  logic [KW-1:0]      r_k;
  logic signed [12:0] r_exp;
  logic               r_sign;
  logic               r_special;
  logic [63:0]        r_spec_z;
  logic               r_spec_inv;
  logic [63:0]        r_z;
  logic               r_done;
  logic               r_invalid;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_sign;
  logic signed [12:0] w_ea;
  logic signed [12:0] w_eb;
  logic signed [12:0] w_exp;
  logic [52:0]        w_sig_a;
  logic [52:0]        w_sig_b;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic               w_invalid;
  logic               w_special;
  logic [63:0]        w_spec_z;
  logic [PPW-1:0]     w_pp_narrow;
  logic [105:0]       w_pp;
  logic [6:0]         w_shamt;
  logic [63:0]        w_rp_z;
  logic               w_rp_ovf;
  logic               w_rp_udf;

  always_comb begin
    w_sign   = bus.i_a[63] ^ bus.i_b[63];
    w_ea     = {2'b00, bus.i_a[62:52]};
    w_eb     = {2'b00, bus.i_b[62:52]};
    w_exp    = w_ea + w_eb - 13'sd1023;
    w_sig_a  = {1'b1, bus.i_a[FRAC_W-1:0]};
    w_sig_b  = {1'b1, bus.i_b[FRAC_W-1:0]};
    w_a_nan  = fp_is_nan(bus.i_a);
    w_b_nan  = fp_is_nan(bus.i_b);
    w_a_inf  = fp_is_inf(bus.i_a);
    w_b_inf  = fp_is_inf(bus.i_b);
    w_a_zero = fp_is_zero(bus.i_a);
    w_b_zero = fp_is_zero(bus.i_b);

    w_invalid = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    w_special = w_invalid | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    if (w_invalid)             w_spec_z = QNAN;
    else if (w_a_inf | w_b_inf) w_spec_z = {w_sign, EXP_INF, 52'd0};
    else                       w_spec_z = {w_sign, 63'd0};
  end

  // High partial-product bits dropped by the shift are always zero: B is zero-extended.
  always_comb begin
    w_pp_narrow = {{ITER_BITS{1'b0}}, r_a} * {{53{1'b0}}, r_b[ITER_BITS-1:0]};
    w_shamt     = 7'(r_k) * 7'(ITER_BITS);
    w_pp        = {{(106-PPW){1'b0}}, w_pp_narrow} << w_shamt;
  end

  fp64_round_pack u_round_pack (
    .i_sign      (r_sign),
    .i_exp       (r_exp),
    .i_prod      (r_p),
    .o_z         (w_rp_z),
    .o_overflow  (w_rp_ovf),
    .o_underflow (w_rp_udf)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.i_start) w_next = w_special ? NORM : MULT;
      MULT:    if (r_k == KW'(ITERS - 1)) w_next = NORM;
      NORM:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_p         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_special   <= 1'b0;
      r_spec_z    <= '0;
      r_spec_inv  <= 1'b0;
      r_z         <= '0;
      r_done      <= 1'b0;
      r_invalid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_sign      <= w_sign;
            r_exp       <= w_exp;
            r_a         <= w_sig_a;
            r_b         <= BW'(w_sig_b);
            r_p         <= '0;
            r_k         <= '0;
            r_special   <= w_special;
            r_spec_z    <= w_spec_z;
            r_spec_inv  <= w_invalid;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end
        end
        MULT: begin
          r_p <= r_p + w_pp;
          r_b <= r_b >> ITER_BITS;
          r_k <= r_k + KW'(1);
        end
        NORM: begin
          r_done <= 1'b1;
          if (r_special) begin
            r_z       <= r_spec_z;
            r_invalid <= r_spec_inv;
          end else begin
            r_z         <= w_rp_z;
            r_overflow  <= w_rp_ovf;
            r_underflow <= w_rp_udf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_done      = r_done;
  assign bus.o_z         = r_z;
  assign bus.o_invalid   = r_invalid;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;

endmodule

// File: tb/tb_fp64_mul_seq.sv
// Directed bench for fp64_mul_seq: expected results are queued when a request
// is accepted and checked against each o_done pulse.
module tb_fp64_mul_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp64_mul_seq_if bus ();

  fp64_mul_seq #(.ITER_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] z;
    logic [2:0]  fl;
    int          acc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.o_done) begin
      n_done++;
      if (q.size() == 0) begin
        chk("spurious_done", 64'(bus.o_done), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_z"}, bus.o_z, e.z);
        chk({e.tag, "_flags"}, 64'({bus.o_invalid, bus.o_overflow, bus.o_underflow}), 64'(e.fl));
        chk({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic issue(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] z, input logic [2:0] fl, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (bus.o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    e.z = z; e.fl = fl; e.acc = cyc + 1; e.lat = lat; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int d0;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_z", bus.o_z, 64'd0);
    chk("rst_busy_done", 64'({bus.o_busy, bus.o_done}), 64'd0);
    chk("rst_flags", 64'({bus.o_invalid, bus.o_overflow, bus.o_underflow}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue("mul_1p5x2", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b000, 15);
    chk("busy_in_mult", 64'(bus.o_busy), 64'd1);
    drain();
    issue("rnd_down", 64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, 3'b000, 15);
    drain();
    issue("rnd_tie_even", 64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 3'b000, 15);
    drain();
    issue("inf_x_zero", 64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 3'b100, 1);
    drain();
    issue("nan_x_one", 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 3'b100, 1);
    drain();
    issue("overflow", 64'h7FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 3'b010, 15);
    drain();
    issue("underflow", 64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 3'b001, 15);
    drain();
    issue("neg_mul", 64'hC000000000000000, 64'h4000000000000000, 64'hC010000000000000, 3'b000, 15);
    drain();
    issue("inf_x_neg", 64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000, 3'b000, 1);
    drain();
    issue("zero_x_neg", 64'h0000000000000000, 64'hC000000000000000, 64'h8000000000000000, 3'b000, 1);
    drain();

    // Starts while busy must be ignored.
    d0 = n_done;
    issue("busy_ign", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b000, 15);
    bus.i_a = 64'h7FF0000000000000;
    bus.i_b = 64'h0;
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("busy_ign_count", 64'(n_done - d0), 64'd1);

    // Start in the o_done cycle.
    issue("b2b_first", 64'hC000000000000000, 64'h4000000000000000, 64'hC010000000000000, 3'b000, 15);
    n = 0;
    while (!bus.o_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 64'(bus.o_done), 64'd1);
    issue("b2b_second", 64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 3'b000, 15);
    drain();

    // Reset during MULT aborts with no o_done.
    d0 = n_done;
    issue("aborted", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b000, 15);
    repeat (6) @(negedge clk);
    q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.o_busy), 64'd0);
    chk("abort_z", bus.o_z, 64'd0);
    chk("abort_done", 64'(bus.o_done), 64'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(n_done - d0), 64'd0);
    issue("after_abort", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b000, 15);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
